// File: rtl/vga_scan_gen.sv
// Raster scan generator: divides the system clock to the pixel rate and produces
// scan position, hsync/vsync, video_on and a frame-start pulse.
module vga_scan_gen #(
  parameter int   DIV      = 2,
  parameter int   H_VIS    = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SW     = 96,
  parameter int   H_BP     = 48,
  parameter int   V_VIS    = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SW     = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        BTN_S,
  output logic        pix_tick,
  output logic [10:0] visible_col,
  output logic [10:0] visible_row,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SW + V_BP;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  // Count values at which each FSM enters the named phase.
  localparam logic [10:0] H_FRONT_AT = 11'(H_VIS);
  localparam logic [10:0] H_SYNC_AT  = 11'(H_VIS + H_FP);
  localparam logic [10:0] H_BACK_AT  = 11'(H_VIS + H_FP + H_SW);
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_FRONT_AT = 11'(V_VIS);
  localparam logic [10:0] V_SYNC_AT  = 11'(V_VIS + V_FP);
  localparam logic [10:0] V_BACK_AT  = 11'(V_VIS + V_FP + V_SW);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);

  localparam logic [1:0] H_VISIBLE = 2'd0;
  localparam logic [1:0] H_FRONT   = 2'd1;
  localparam logic [1:0] H_SYNC    = 2'd2;
  localparam logic [1:0] H_BACK    = 2'd3;
  localparam logic [1:0] V_VISIBLE = 2'd0;
  localparam logic [1:0] V_FRONT   = 2'd1;
  localparam logic [1:0] V_SYNC    = 2'd2;
  localparam logic [1:0] V_BACK    = 2'd3;

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic [10:0]      h_cnt;
  logic [10:0]      v_cnt;
  logic [10:0]      h_next;
  logic [10:0]      v_next;
  logic [1:0]       h_state;
  logic [1:0]       v_state;
  logic [1:0]       h_state_next;
  logic [1:0]       v_state_next;
  logic             h_wrap;
  logic             v_wrap;

  // Decoded straight from the divider register so the tick and the advance
  // edge line up with no added latency.
  assign pix_tick    = (div_cnt == DIV_LAST);
  assign visible_col = h_cnt;
  assign visible_row = v_cnt;

  assign div_next = pix_tick ? '0 : div_cnt + 1'b1;
  assign h_wrap   = (h_cnt == H_LAST);
  assign v_wrap   = (v_cnt == V_LAST);
  assign h_next   = h_wrap ? 11'd0 : h_cnt + 11'd1;
  assign v_next   = h_wrap ? (v_wrap ? 11'd0 : v_cnt + 11'd1) : v_cnt;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    h_state_next = h_state;
    case (h_state)
      H_VISIBLE: if (h_next == H_FRONT_AT) h_state_next = H_FRONT;
      H_FRONT:   if (h_next == H_SYNC_AT)  h_state_next = H_SYNC;
      H_SYNC:    if (h_next == H_BACK_AT)  h_state_next = H_BACK;
      default:   if (h_next == 11'd0)      h_state_next = H_VISIBLE;
    endcase
  end

  // Vertical phase moves only on the edge that ends a line.
  always_comb begin
    v_state_next = v_state;
    if (h_wrap) begin
      case (v_state)
        V_VISIBLE: if (v_next == V_FRONT_AT) v_state_next = V_FRONT;
        V_FRONT:   if (v_next == V_SYNC_AT)  v_state_next = V_SYNC;
        V_SYNC:    if (v_next == V_BACK_AT)  v_state_next = V_BACK;
        default:   if (v_next == 11'd0)      v_state_next = V_VISIBLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge BTN_S) begin
    if (BTN_S) begin
      div_cnt     <= '0;
      h_cnt       <= 11'd0;
      v_cnt       <= 11'd0;
      h_state     <= H_VISIBLE;
      v_state     <= V_VISIBLE;
      video_on    <= 1'b1;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= div_next;
      frame_start <= 1'b0;
      if (pix_tick) begin
        h_cnt       <= h_next;
        v_cnt       <= v_next;
        h_state     <= h_state_next;
        v_state     <= v_state_next;
        video_on    <= (h_state_next == H_VISIBLE) && (v_state_next == V_VISIBLE);
        hsync       <= (h_state_next == H_SYNC) ? SYNC_POL : ~SYNC_POL;
        vsync       <= (v_state_next == V_SYNC) ? SYNC_POL : ~SYNC_POL;
        frame_start <= h_wrap && v_wrap;
      end
    end
  end

endmodule

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
- Generates raster scan position and sync timing for the VGA display path: pixel tick, hsync, vsync, video_on, and the visible_col/visible_row coordinates.
- Shape/region detectors (bottle, neck, sand bricks) consume visible_col/visible_row and compare them against their col/row anchors.
- Runs on the system clock and divides it down to the pixel rate internally.

Parameters:
- DIV, 2, system clocks per pixel (>=1)
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SW, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SW, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk  input  1  system clock
- BTN_S  input  1  asynchronous active-high reset
- pix_tick  output  1  high for one clk when the scan position advances
- visible_col  output  11  current horizontal count, 0..H_TOTAL-1
- visible_row  output  11  current vertical count, 0..V_TOTAL-1
- video_on  output  1  high when visible_col<H_VIS and visible_row<V_VIS
- hsync  output  1  horizontal sync at SYNC_POL level during the sync phase
- vsync  output  1  vertical sync at SYNC_POL level during the sync phase
- frame_start  output  1  one-clk pulse when the position wraps to (0,0)

Behaviour:
- Totals: H_TOTAL = H_VIS+H_FP+H_SW+H_BP (800), V_TOTAL = V_VIS+V_FP+V_SW+V_BP (525). Both must be <=2048. Counters are 11-bit unsigned; no other widths.
- Reset (BTN_S high, async): div_cnt=0, h_cnt=0, v_cnt=0, h_state=H_VISIBLE, v_state=V_VISIBLE. Output values during reset:
  - visible_col=0, visible_row=0, video_on=1
  - hsync=vsync=~SYNC_POL
  - frame_start=0
- Reset may assert at any cycle, including mid-line or mid-sync. All state is cleared immediately. Scanning resumes from (0,0) on the first tick after release. No frame_start is issued for that resume.
- Divider: div_cnt counts 0..DIV-1 and wraps. pix_tick is high exactly when div_cnt==DIV-1; it is decoded from the register, not delayed. With DIV=1, pix_tick is constantly high after reset.
- Advance: on a clk edge with pix_tick=1:
  - h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 after V_TOTAL-1 when h_cnt also wraps.
  - No advance occurs on edges without pix_tick.
- Horizontal FSM, evaluated on the advance edge with the new h_cnt:
  - H_VISIBLE (0..H_VIS-1) -> H_FRONT at h_cnt=H_VIS
  - H_FRONT -> H_SYNC at H_VIS+H_FP
  - H_SYNC -> H_BACK at H_VIS+H_FP+H_SW
  - H_BACK -> H_VISIBLE at wrap to 0
- Vertical FSM: same structure with V_* states and v_cnt boundaries. It transitions only on edges where h_cnt wraps.
- Outputs are registered and updated on the same advance edge from the new counter/state values. There is no extra latency: visible_col/visible_row equal the internal counters.
  - video_on = (h_state==H_VISIBLE) and (v_state==V_VISIBLE)
  - hsync = SYNC_POL when h_state==H_SYNC, else ~SYNC_POL
  - vsync = SYNC_POL when v_state==V_SYNC, else ~SYNC_POL
- Outputs hold between ticks. Downstream consumers must sample region flags qualified by video_on.
- frame_start: high for exactly one clk, on the advance edge where (h_cnt,v_cnt) becomes (0,0) by wrap from (H_TOTAL-1,V_TOTAL-1). Never asserted by reset.
- Simultaneous horizontal and vertical wrap: both FSMs update on the same edge. At the frame boundary, hsync and vsync are both inactive and video_on=1.

Test Plan:
- Reset: hold BTN_S for 5 clk -> col=0, row=0, video_on=1, hsync=vsync=1, frame_start=0, pix_tick=0. Release -> first pix_tick at clk 2, col becomes 1 on that edge.
- Divider: DIV=2, 20 clk -> pix_tick high on alternate clks (10 pulses). Rerun with DIV=1 -> pix_tick continuously high, col increments every clk.
- Line timing: run one line -> video_on high for cols 0..639 (640 ticks), hsync low for cols 656..751 (96 ticks). At col 799->0 on a tick, row increments 0->1.
- Frame timing: run a full frame -> vsync low for rows 490..491 (2*800 ticks), video_on low for rows >=480. Row 524 col 799 -> (0,0) with a single frame_start pulse. Next frame_start exactly 420000 ticks later.
- Async reset mid-sync: assert BTN_S between clk edges at col 700 (hsync low) -> outputs go to reset values immediately, without a clk edge. After release, no frame_start and scan restarts at (0,0).
- Boundary hold: between ticks (DIV=4) -> col/row/hsync/vsync/video_on stable for all 4 clks. Each output changes only on a pix_tick edge.
